oneshot_arbiter: RTL and testbench

Collects rising edges from N asynchronous-free, clock-synchronous level inputs and turns each edge into a pending request. Requests share a single downstream resource, such as one command engine or one LED/serial sequencer. Pending requests are granted one at a time in round-robin order, using a start/done handshake with a timeout guard. The block sits between the per-input edge detection and the shared consumer, and replaces per-channel pulse logic with one scheduler.

---
 rtl/oneshot_arbiter.sv | 122 ++++++++++++
 tb/tb_oneshot_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/oneshot_arbiter.sv
// rtl/oneshot_arbiter.sv - turns rising edges on N level inputs into requests and
// grants them one at a time, round-robin, over a start/done handshake with timeout.
module oneshot_arbiter #(
   parameter int N         = 4,
   parameter int TIMEOUT_W = 8,
   parameter int TIMEOUT   = 200
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         in,
   input  logic                 done,
   output logic                 start,
   output logic [$clog2(N)-1:0] grant_id,
   output logic [N-1:0]         grant_onehot,
   output logic                 busy,
   output logic [N-1:0]         pending,
   output logic [N-1:0]         dropped,
   output logic                 timeout
);
   localparam int W = $clog2(N);
   localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

   state_t               state, state_next;
   logic [N-1:0]         in_d, rise, clear;
   logic [N-1:0]         pending_next, dropped_next, onehot_next;
   logic [W-1:0]         rr, rr_next, winner, idx, grant_id_next;
   logic [TIMEOUT_W-1:0] cnt, cnt_next;
   logic                 timeout_next, found;

   assign rise  = in & ~in_d;
   assign busy  = (state != IDLE);
   assign start = (state == START);

   // First pending channel after the last winner, wrapping modulo N.
   always_comb begin
      winner = rr;
      found  = 1'b0;
      idx    = '0;
      for (int k = 1; k <= N; k++) begin
         idx = W'((int'(rr) + k) % N);
         if (!found && pending[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_next    = state;
      rr_next       = rr;
      cnt_next      = cnt;
      timeout_next  = 1'b0;
      grant_id_next = grant_id;
      onehot_next   = grant_onehot;
      clear         = '0;
      case (state)
         IDLE: begin
            if (found) begin
               state_next    = START;
               rr_next       = winner;
               grant_id_next = winner;
               onehot_next   = N'(1) << winner;
               clear         = N'(1) << winner;
            end
         end
         START: begin
            state_next = WAIT;
            cnt_next   = '0;
         end
         WAIT: begin
            cnt_next = cnt + TIMEOUT_W'(1);
            if (done) begin
               state_next    = IDLE;
               grant_id_next = '0;
               onehot_next   = '0;
            end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
               state_next    = IDLE;
               grant_id_next = '0;
               onehot_next   = '0;
               timeout_next  = 1'b1;
            end
         end
         default: begin
            state_next    = IDLE;
            grant_id_next = '0;
            onehot_next   = '0;
         end
      endcase
      // A fresh edge on the channel being granted re-arms it rather than being lost.
      pending_next = (pending & ~clear) | rise;
      dropped_next = dropped | (rise & pending & ~clear);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_d         <= '1;
         pending      <= '0;
         dropped      <= '0;
         rr           <= W'(N - 1);
         cnt          <= '0;
         grant_id     <= '0;
         grant_onehot <= '0;
         timeout      <= 1'b0;
      end else begin
         in_d         <= in;
         pending      <= pending_next;
         dropped      <= dropped_next;
         rr           <= rr_next;
         cnt          <= cnt_next;
         grant_id     <= grant_id_next;
         grant_onehot <= onehot_next;
         timeout      <= timeout_next;
      end
   end
endmodule

// File: tb/tb_oneshot_arbiter.sv
// tb/tb_oneshot_arbiter.sv - self-checking bench for oneshot_arbiter.
module tb_oneshot_arbiter;
   localparam int N  = 4;
   localparam int TO = 5;

   logic         clk = 1'b0;
   logic         reset, done, start, busy, timeout;
   logic [N-1:0] in, grant_onehot, pending, dropped;
   logic [1:0]   grant_id;
   int           n_cmp = 0;
   int           n_err = 0;

   oneshot_arbiter #(.N(N), .TIMEOUT_W(8), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .in(in), .done(done), .start(start),
      .grant_id(grant_id), .grant_onehot(grant_onehot), .busy(busy),
      .pending(pending), .dropped(dropped), .timeout(timeout)
   );

   always #5 clk = ~clk;

   // Reference model: m_svc is the channel in service (-1 none), m_age counts
   // cycles since the grant was taken (1 = start cycle, 2.. = waiting cycles).
   logic [N-1:0] m_in_d, m_pend, m_drop;
   int           m_svc, m_age, m_rr;
   logic         m_to;

   task automatic model_reset();
      m_in_d = '1; m_pend = '0; m_drop = '0;
      m_svc = -1; m_age = 0; m_rr = N - 1; m_to = 1'b0;
   endtask

   task automatic model_clock();
      logic [N-1:0] rise, clr;
      if (reset) begin
         model_reset();
         return;
      end
      rise = in & ~m_in_d;
      clr  = '0;
      m_to = 1'b0;
      if (m_svc < 0) begin
         for (int k = 1; k <= N; k++)
            if (m_svc < 0 && m_pend[(m_rr + k) % N]) m_svc = (m_rr + k) % N;
         if (m_svc >= 0) begin
            m_age = 1; m_rr = m_svc; clr[m_svc] = 1'b1;
         end
      end else if (m_age == 1) m_age = 2;
      else if (done) m_svc = -1;
      else if (m_age - 2 == TO - 1) begin
         m_svc = -1; m_to = 1'b1;
      end else m_age++;
      m_drop = m_drop | (rise & m_pend & ~clr);
      m_pend = (m_pend & ~clr) | rise;
      m_in_d = in;
   endtask

   task automatic step();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_out(string tag, logic st, logic bz, int gid,
                            logic [N-1:0] pd, logic [N-1:0] dr, logic to);
      check({tag, ".start"},   32'(start),        32'(st));
      check({tag, ".busy"},    32'(busy),         32'(bz));
      check({tag, ".gid"},     32'(grant_id),     32'(gid));
      check({tag, ".onehot"},  32'(grant_onehot), bz ? 32'(1) << gid : 32'(0));
      check({tag, ".pending"}, 32'(pending),      32'(pd));
      check({tag, ".dropped"}, 32'(dropped),      32'(dr));
      check({tag, ".timeout"}, 32'(timeout),      32'(to));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   typedef struct {
      logic rst; logic [N-1:0] in; logic done;
      logic st; logic bz; int gid; logic [N-1:0] pd; logic [N-1:0] dr; logic to;
   } vec_t;
   vec_t vt[$];

   task automatic add(logic rst, logic [N-1:0] i, logic d, logic st, logic bz,
                      int gid, logic [N-1:0] pd, logic [N-1:0] dr, logic to);
      vec_t v;
      v.rst = rst; v.in = i; v.done = d; v.st = st; v.bz = bz;
      v.gid = gid; v.pd = pd; v.dr = dr; v.to = to;
      vt.push_back(v);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int got[$];
      int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
      // rst, in, done | start, busy, gid, pending, dropped, timeout
      add(0, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
      add(0, 4'b0010, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
      add(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
      add(0, 4'b0010, 0, 0, 0, 0, 4'b0010, 4'b0000, 0);
      add(0, 4'b0010, 0, 1, 1, 1, 4'b0000, 4'b0000, 0);
      add(0, 4'b0010, 0, 0, 1, 1, 4'b0000, 4'b0000, 0);
      add(0, 4'b0010, 1, 0, 0, 0, 4'b0000, 4'b0000, 0);
      add(1, 4'b1111, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
      add(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
      add(0, 4'b1101, 0, 0, 0, 0, 4'b1101, 4'b0000, 0);
      add(0, 4'b1101, 0, 1, 1, 0, 4'b1100, 4'b0000, 0);
      add(0, 4'b1101, 1, 0, 1, 0, 4'b1100, 4'b0000, 0);
      add(0, 4'b1101, 1, 0, 0, 0, 4'b1100, 4'b0000, 0);
      add(0, 4'b1101, 0, 1, 1, 2, 4'b1000, 4'b0000, 0);
      add(0, 4'b1101, 0, 0, 1, 2, 4'b1000, 4'b0000, 0);
      add(0, 4'b1101, 1, 0, 0, 0, 4'b1000, 4'b0000, 0);
      add(0, 4'b1101, 0, 1, 1, 3, 4'b0000, 4'b0000, 0);
      add(0, 4'b1101, 0, 0, 1, 3, 4'b0000, 4'b0000, 0);
      add(0, 4'b1101, 1, 0, 0, 0, 4'b0000, 4'b0000, 0);
      add(0, 4'b1000, 0, 0, 0, 0, 4'b0000, 4'b0000, 0);
      add(0, 4'b1001, 0, 0, 0, 0, 4'b0001, 4'b0000, 0);
      add(0, 4'b1101, 0, 1, 1, 0, 4'b0100, 4'b0000, 0);
      add(0, 4'b1001, 0, 0, 1, 0, 4'b0100, 4'b0000, 0);
      add(0, 4'b1001, 1, 0, 0, 0, 4'b0100, 4'b0000, 0);
      add(0, 4'b1101, 0, 1, 1, 2, 4'b0100, 4'b0000, 0);
      add(0, 4'b1101, 0, 0, 1, 2, 4'b0100, 4'b0000, 0);
      add(0, 4'b1001, 0, 0, 1, 2, 4'b0100, 4'b0000, 0);
      add(0, 4'b1101, 0, 0, 1, 2, 4'b0100, 4'b0100, 0);
      add(0, 4'b1101, 1, 0, 0, 0, 4'b0100, 4'b0100, 0);
      add(0, 4'b1101, 0, 1, 1, 2, 4'b0000, 4'b0100, 0);
      add(0, 4'b1101, 0, 0, 1, 2, 4'b0000, 4'b0100, 0);
      add(0, 4'b1101, 1, 0, 0, 0, 4'b0000, 4'b0100, 0);

      reset = 1'b1; in = 4'b0010; done = 1'b0;
      model_reset();
      step();
      step();
      check_out("reset", 0, 0, 0, 4'b0000, 4'b0000, 0);

      foreach (vt[i]) begin
         reset = vt[i].rst; in = vt[i].in; done = vt[i].done;
         step();
         check_out($sformatf("vec%0d", i), vt[i].st, vt[i].bz, vt[i].gid,
                   vt[i].pd, vt[i].dr, vt[i].to);
      end

      // Timeout after five waiting cycles without done.
      reset = 1'b0; done = 1'b0; in = 4'b0101;
      step();
      in = 4'b1101; step();
      step(); check_out("to_start", 1, 1, 3, 4'b0000, 4'b0100, 0);
      step();
      for (int w = 1; w <= TO; w++) begin
         step();
         if (w < TO) check_out($sformatf("to_wait%0d", w), 0, 1, 3, 4'b0000, 4'b0100, 0);
         else        check_out("to_pulse", 0, 0, 0, 4'b0000, 4'b0100, 1);
      end
      step(); check_out("to_after", 0, 0, 0, 4'b0000, 4'b0100, 0);

      // done coinciding with the last waiting cycle suppresses the timeout.
      in = 4'b0101; step();
      in = 4'b1101; step();
      step(); step();
      for (int w = 1; w < TO; w++) step();
      done = 1'b1; step();
      check_out("tie_done", 0, 0, 0, 4'b0000, 4'b0100, 0);
      done = 1'b0; step();
      check_out("tie_after", 0, 0, 0, 4'b0000, 4'b0100, 0);

      // Asynchronous reset in the middle of a wait on channel 3.
      in = 4'b0101; step();
      in = 4'b1101; step();
      step(); step();
      in = 4'b1100; step();
      in = 4'b1101; step();
      check_out("pre_rst", 0, 1, 3, 4'b0001, 4'b0100, 0);
      #2 reset = 1'b1;
      #1 check_out("rst_async", 0, 0, 0, 4'b0000, 4'b0000, 0);
      step();
      check_out("rst_held", 0, 0, 0, 4'b0000, 4'b0000, 0);
      reset = 1'b0; step();
      check_out("rst_rel", 0, 0, 0, 4'b0000, 4'b0000, 0);
      in = 4'b1111; step();
      check_out("post_pend", 0, 0, 0, 4'b0010, 4'b0000, 0);
      done = 1'b1; step();
      check_out("post_start", 1, 1, 1, 4'b0000, 4'b0000, 0);
      step(); step();
      check_out("post_idle", 0, 0, 0, 4'b0000, 4'b0000, 0);

      // Every channel kept pending: grants rotate strictly.
      do_reset();
      in = 4'b0000; done = 1'b1; step();
      for (int c = 0; c < 100 && got.size() < 6; c++) begin
         in = ~in;
         step();
         if (start) got.push_back(int'(grant_id));
      end
      check("rr_count", 32'(got.size()), 32'd6);
      for (int i = 0; i < 6 && i < got.size(); i++)
         check($sformatf("rr_grant%0d", i), 32'(got[i]), 32'(exp_seq[i]));

      // Randomized traffic against the model.
      do_reset();
      in = '0; done = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 3) == 0) in[b] = ~in[b];
         done = ($urandom_range(0, 2) == 0);
         step();
         check_out($sformatf("rnd%0d", c), m_svc >= 0 && m_age == 1, m_svc >= 0,
                   m_svc >= 0 ? m_svc : 0, m_pend, m_drop, m_to);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
